// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, one bit per cycle.
module ex_muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  logic              sa_en;
  logic              sb_en;
  logic              sgn_a;
  logic              sgn_b;
  logic              neg_d;
  logic              div0;
  logic              ovf;
  logic              special;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   spec_res;

  always_comb begin
    sa_en = (op == 3'd1) | (op == 3'd2)
          | (op == 3'd4) | (op == 3'd6);
    sb_en = (op == 3'd1) | (op == 3'd4)
          | (op == 3'd6);
    sgn_a = sa_en & a[XLEN-1];
    sgn_b = sb_en & b[XLEN-1];
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;
    // Remainder takes the dividend's sign only.
    neg_d = (op[2] & op[1]) ? sgn_a
                            : (sgn_a ^ sgn_b);
    div0  = op[2] & (b == '0);
    ovf   = op[2] & ~op[0]
          & (a == {1'b1, {(XLEN-1){1'b0}}})
          & (&b);
    special = div0 | ovf;
    if (div0) begin
      spec_res = op[1] ? a : '1;
    end else begin
      spec_res = op[1] ? '0 : a;
    end
  end

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shl;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   hi_d;
  logic [XLEN-1:0]   lo_d;

  always_comb begin
    sum  = {1'b0, hi_q}
         + (lo_q[0] ? {1'b0, opb_q} : '0);
    shl  = {hi_q, lo_q[XLEN-1]};
    diff = shl - {1'b0, opb_q};
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = shl[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod  = neg_q ? -{hi_q, lo_q}
                  : {hi_q, lo_q};
    quo_s = neg_q ? -lo_q : lo_q;
    rem_s = neg_q ? -hi_q : hi_q;
    fix_res = '0;
    unique case (1'b1)
      op_q[2] & op_q[1]:
        fix_res = rem_s;
      op_q[2] & ~op_q[1]:
        fix_res = quo_s;
      ~op_q[2] & (op_q[1:0] == 2'b00):
        fix_res = prod[XLEN-1:0];
      ~op_q[2] & (op_q[1:0] != 2'b00):
        fix_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              op_q  <= op;
              neg_q <= neg_d;
              hi_q  <= '0;
              cnt_q <= '0;
              opb_q <= op[2] ? mag_b : mag_a;
              lo_q  <= op[2] ? mag_a : mag_b;
              if (special) begin
                result_q <= spec_res;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                busy_q  <= 1'b1;
                state_q <= S_CALC;
              end
            end
          end
          S_CALC: begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
              state_q <= S_FIX;
            end
          end
          S_FIX: begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign stall  = ~flush
                & ((state_q == S_IDLE & start)
                 | (state_q == S_CALC)
                 | (state_q == S_FIX));
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus random
// operations against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y);
    longint sx;
    longint sy;
    longint uy;
    longint p;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    pu = {32'd0, x} * {32'd0, y};
    case (o)
      3'd0: return pu[31:0];
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN && y == 32'hFFFF_FFFF) return MIN;
        p = sx / sy;
        return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy;
        return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_of(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y);
    if (o[2] && (y == 0 ||
        (!o[0] && x == MIN && y == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 2;
  endfunction

  task automatic do_op(input string tag,
                       input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input bit hold);
    logic [31:0] e;
    int l;
    int bad;
    bit got;
    e = model(o, x, y);
    l = lat_of(o, x, y);
    bad = 0;
    got = 0;
    @(negedge clk);
    if (done || busy) bad++;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    #1;
    chk({tag, "_stall_t"}, 32'(stall), 32'd1);
    for (int n = 1; n <= XLEN + 8; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        chk({tag, "_lat"}, 32'(n), 32'(l));
        chk({tag, "_res"}, result, e);
        if (stall || busy) bad++;
        break;
      end
      if (!stall || !busy) bad++;
      if (result !== last_res) bad++;
      if (n == 1) begin
        start = hold;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
      end
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_hold"}, 32'(bad), 32'd0);
    last_res = e;
    if (hold) begin
      @(negedge clk);
      chk({tag, "_pulse"}, 32'({done, busy}), 32'd0);
      start = 1'b0;
      bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (done || busy || stall) bad++;
      end
      chk({tag, "_norestart"}, 32'(bad), 32'd0);
    end else begin
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bad;
    repeat (2) @(negedge clk);
    chk("rst_out",
        {done, busy, stall, 29'd0} | result, 32'd0);
    reset = 1'b0;

    do_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD, 0);
    do_op("mulhu",  3'd3, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 0);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu",   3'd5, 32'd100, 32'd7, 0);
    do_op("remu",   3'd7, 32'd100, 32'd7, 0);
    do_op("divu0",  3'd5, 32'd5, 32'd0, 0);
    do_op("rem0",   3'd6, 32'd5, 32'd0, 0);
    do_op("divovf", 3'd4, MIN, 32'hFFFF_FFFF, 0);
    do_op("removf", 3'd6, MIN, 32'hFFFF_FFFF, 0);
    do_op("divuw",  3'd5, MIN, 32'hFFFF_FFFF, 0);
    do_op("hold",   3'd1, 32'h1234_5678,
          32'h9ABC_DEF0, 1);
    do_op("hold0",  3'd4, 32'd9, 32'd0, 1);
    do_op("next",   3'd6, 32'h8000_0007, 32'd5, 0);

    @(negedge clk);
    start = 1'b1;
    op = 3'd4;
    a = 32'd1000;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", 32'({busy, done}), 32'd0);
    bad = 0;
    repeat (XLEN + 6) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("flush_nodone", 32'(bad), 32'd0);
    chk("flush_res", result, last_res);

    do_op("postfl", 3'd0, 32'hFFFF_FFFF, 32'd3, 0);

    @(negedge clk);
    start = 1'b1;
    op = 3'd7;
    a = 32'd77;
    b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_out", {done, busy, stall, 29'd0}, 32'd0);
    chk("arst_res", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;

    for (int i = 0; i < 60; i++) begin
      do_op("rand", 3'($urandom), pick(), pick(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multi-cycle RV32M multiply/divide unit in the execute stage.
- Operands come from the ID/EX register outputs (operand A = rs1 value, operand B = rs2 value).
- Returns a result to the EX result mux.
- Drives a stall that holds the ID/EX register (enable low) and upstream stages until the result is ready.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 4.
- CNT_W, $clog2(XLEN), iteration-counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of in-flight op (branch mispredict/trap); same cycle as ID/EX clear.
- start  in  1  EX instruction is an M-extension op (from controlsgs), valid this cycle.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- stall  out  1  hold pipeline (combinational).
- busy  out  1  FSM not in IDLE/DONE (registered).
- done  out  1  result valid, single-cycle pulse.
- result  out  XLEN  selected product half / quotient / remainder.

Behaviour:
- Reset (async): state=IDLE, counter=0, all datapath regs=0, done=0, busy=0, result=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 → capture op, |a|, |b| as required by signedness, result-sign flags.
  - Special case → DONE next cycle.
  - Otherwise → CALC with counter=0.
- Special cases (1-cycle, T+1 done):
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU remainder = a.
  - Signed overflow a=0x8000_0000, b=0xFFFF_FFFF: DIV → 0x8000_0000; REM → 0.
  - Multiplies have no special case.
- CALC: one iteration per cycle, XLEN cycles (counter 0..XLEN-1), then → FIX.
  - Multiply: shift-add over unsigned magnitudes; 2·XLEN-bit accumulator.
  - Divide: restoring radix-2; remainder reg XLEN+1 bits.
- FIX: apply sign correction (two's-complement negate where sign flag set), select low or high half / quotient / remainder, then → DONE.
  - MULHSU: a signed, b unsigned.
  - REM sign = sign of a.
  - DIV sign = sign(a) XOR sign(b).
- DONE: done=1 for exactly this cycle; → IDLE unconditionally. start is ignored in DONE, because the same instruction is still presenting start.
- Latency (start in IDLE at cycle T):
  - Normal op: CALC T+1..T+XLEN, FIX T+XLEN+1, DONE T+XLEN+2 (34 cycles after T for XLEN=32).
  - Special case: DONE at T+1.
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX. Low in DONE, so the instruction advances on the done cycle.
- result register updates only on entry to DONE and holds until the next DONE; it is stable while the next op is in flight.
- flush has priority over start and over every state: next state=IDLE, done=0, result unchanged, stall deasserts the same cycle.
- Reset mid-operation: immediate return to IDLE, outputs to reset values.
- Operands are sampled only at acceptance. Changes to a, b, op during CALC/FIX have no effect.
- Back-to-back M ops: the second is accepted in the IDLE cycle after DONE; no bubble beyond that.

Test Plan:
- MUL 7×(-3) (a=0x7, b=0xFFFF_FFFD) → stall high T..T+33, done at T+34, result 0xFFFF_FFEB; MULH same operands → 0xFFFF_FFFF.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE; MULHSU a=0xFFFF_FFFF, b=0x2 → 0xFFFF_FFFF.
- DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU → 2; each with done at T+34.
- DIVU 5/0 → 0xFFFF_FFFF, REM 5/0 → 5, DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000, REM same → 0; all done at T+1, stall high only in cycle T.
- Start held high through DONE → exactly one done pulse, no restart. Next start in IDLE → second result correct, previous result held until the new done.
- flush at T+10 of a DIV → stall low same cycle, state IDLE, no done pulse, result keeps prior value. Async reset at T+5 → all outputs 0 immediately.
